// File: rtl/lock_pkg.sv
// Shared types and helpers for the keypad lock controller.
package lock_pkg;
  localparam int DIGIT_W   = 4;
  localparam int KEY_LINES = 16;

  typedef enum logic [2:0] {
    S_IDLE,
    S_ENTRY,
    S_CHECK,
    S_UNLOCK,
    S_PROG,
    S_LOCKOUT
  } state_e;

  typedef struct packed {
    logic               stb;
    logic [DIGIT_W-1:0] code;
  } key_evt_t;

  function automatic logic is_onehot(input logic [KEY_LINES-1:0] v);
    return (v != '0) && ((v & (v - KEY_LINES'(1))) == '0);
  endfunction

  function automatic logic [DIGIT_W-1:0] onehot_idx(input logic [KEY_LINES-1:0] v);
    logic [DIGIT_W-1:0] idx;
    idx = '0;
    for (int i = 0; i < KEY_LINES; i++)
      if (v[i]) idx = idx | DIGIT_W'(i);
    return idx;
  endfunction

  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction
endpackage

// File: rtl/lock_entry_ctrl_if.sv
// Keypad in / lock status out bundle; master is the keypad side, slave the controller.
interface lock_entry_ctrl_if #(parameter int MAX_TRY = 3);
  import lock_pkg::*;
  localparam int TRY_W = $clog2(MAX_TRY + 1);

  logic [KEY_LINES-1:0] x;
  logic                 prog_req;
  logic                 z;
  logic [TRY_W-1:0]     try_cnt;
  logic                 reset_try;
  logic                 lockout;
  logic                 key_stb;
  logic [DIGIT_W-1:0]   key_code;
  logic                 prog_mode;

  modport master (output x, prog_req,
                  input  z, try_cnt, reset_try, lockout, key_stb, key_code, prog_mode);
  modport slave  (input  x, prog_req,
                  output z, try_cnt, reset_try, lockout, key_stb, key_code, prog_mode);
endinterface

// File: rtl/lock_entry_ctrl_key_qualifier.sv
// Registers the keypad lines and emits one strobe per clean press (one-hot after all-zero).
module key_qualifier
  import lock_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst,
  input  logic [KEY_LINES-1:0] x,
  output key_evt_t             key
);
  logic [KEY_LINES-1:0] x_q, x_d;
  logic                 rel_q, rel_d;
  key_evt_t             key_q, key_d;

  // rel_q remembers whether the previous sample was all-zero; multi-hot is not a release
  always_comb begin
    x_d       = x;
    rel_d     = (x_q == '0);
    key_d.stb = is_onehot(x_q) && rel_q;
    key_d.code = key_d.stb ? onehot_idx(x_q) : '0;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      x_q   <= '0;
      rel_q <= 1'b1;
      key_q <= '0;
    end else begin
      x_q   <= x_d;
      rel_q <= rel_d;
      key_q <= key_d;
    end
  end

  assign key = key_q;
endmodule

// File: rtl/lock_entry_ctrl.sv
// Keypad sequencing FSM: digit assembly, code compare, unlock/lockout timing, reprogramming.
module lock_entry_ctrl
  import lock_pkg::*;
#(
  parameter int                            CODE_LEN     = 4,
  parameter logic [DIGIT_W*CODE_LEN-1:0]   DEFAULT_CODE = 16'h1234,
  parameter int                            MAX_TRY      = 3,
  parameter int                            UNLOCK_CYC   = 8,
  parameter int                            LOCK_CYC     = 32,
  parameter int                            TIMEOUT_CYC  = 64
) (
  input  logic              clk,
  input  logic              rst,
  lock_entry_ctrl_if.slave  bus
);
  localparam int CODE_W = DIGIT_W * CODE_LEN;
  localparam int TRY_W  = $clog2(MAX_TRY + 1);
  localparam int CNT_W  = $clog2(CODE_LEN + 1);
  localparam int TMR_W  = $clog2(max3(LOCK_CYC, TIMEOUT_CYC, UNLOCK_CYC) + 1);

  localparam logic [TMR_W-1:0] T_UNLOCK = TMR_W'(UNLOCK_CYC - 1);
  localparam logic [TMR_W-1:0] T_LOCK   = TMR_W'(LOCK_CYC - 1);
  localparam logic [TMR_W-1:0] T_TOUT   = TMR_W'(TIMEOUT_CYC - 1);
  localparam logic [TRY_W-1:0] TRY_MAX  = TRY_W'(MAX_TRY);

  key_evt_t key;

  key_qualifier u_kq (
    .clk (clk),
    .rst (rst),
    .x   (bus.x),
    .key (key)
  );

  state_e            state_q, state_d;
  logic [CODE_W-1:0] buf_q, buf_d;
  logic [CODE_W-1:0] shd_q, shd_d;
  logic [CODE_W-1:0] code_q, code_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [TMR_W-1:0]  tmr_q, tmr_d;
  logic [TRY_W-1:0]  try_q, try_d;
  logic              z_q, z_d;
  logic              lock_q, lock_d;
  logic              prog_q, prog_d;
  logic              rtry_q, rtry_d;

  logic [CODE_W-1:0] buf_sh, shd_sh;
  logic [CNT_W-1:0]  cnt_inc;
  logic              last_digit;
  logic [TRY_W-1:0]  try_inc;

  // First digit entered ends up in the MS nibble after CODE_LEN shifts
  assign buf_sh     = (buf_q << DIGIT_W) | CODE_W'(key.code);
  assign shd_sh     = (shd_q << DIGIT_W) | CODE_W'(key.code);
  assign cnt_inc    = cnt_q + CNT_W'(1);
  assign last_digit = (cnt_inc == CNT_W'(CODE_LEN));
  assign try_inc    = (try_q == TRY_MAX) ? try_q : try_q + TRY_W'(1);

  always_comb begin
    state_d = state_q;
    buf_d   = buf_q;
    shd_d   = shd_q;
    code_d  = code_q;
    cnt_d   = cnt_q;
    tmr_d   = tmr_q;
    try_d   = try_q;
    z_d     = z_q;
    lock_d  = lock_q;
    prog_d  = prog_q;
    rtry_d  = 1'b0;

    case (state_q)
      // IDLE holds an empty buffer and zero count, so it shares ENTRY's key path
      S_IDLE, S_ENTRY: begin
        if (key.stb) begin
          buf_d   = buf_sh;
          cnt_d   = cnt_inc;
          tmr_d   = T_TOUT;
          state_d = last_digit ? S_CHECK : S_ENTRY;
        end else if (state_q == S_ENTRY) begin
          if (tmr_q == '0) begin
            buf_d   = '0;
            cnt_d   = '0;
            state_d = S_IDLE;
          end else begin
            tmr_d = tmr_q - TMR_W'(1);
          end
        end
      end

      S_CHECK: begin
        buf_d = '0;
        cnt_d = '0;
        if (buf_q == code_q) begin
          try_d   = '0;
          rtry_d  = (try_q != '0);
          z_d     = 1'b1;
          tmr_d   = T_UNLOCK;
          state_d = S_UNLOCK;
        end else begin
          try_d = try_inc;
          if (try_inc == TRY_MAX) begin
            lock_d  = 1'b1;
            tmr_d   = T_LOCK;
            state_d = S_LOCKOUT;
          end else begin
            state_d = S_IDLE;
          end
        end
      end

      // prog_req wins over expiry, including on the final unlock cycle
      S_UNLOCK: begin
        if (bus.prog_req) begin
          z_d     = 1'b0;
          prog_d  = 1'b1;
          cnt_d   = '0;
          shd_d   = '0;
          tmr_d   = T_TOUT;
          state_d = S_PROG;
        end else if (tmr_q == '0) begin
          z_d     = 1'b0;
          state_d = S_IDLE;
        end else begin
          tmr_d = tmr_q - TMR_W'(1);
        end
      end

      S_PROG: begin
        if (key.stb) begin
          shd_d = shd_sh;
          cnt_d = cnt_inc;
          tmr_d = T_TOUT;
          if (last_digit) begin
            code_d  = shd_sh;
            cnt_d   = '0;
            prog_d  = 1'b0;
            state_d = S_IDLE;
          end
        end else if (tmr_q == '0) begin
          cnt_d   = '0;
          prog_d  = 1'b0;
          state_d = S_IDLE;
        end else begin
          tmr_d = tmr_q - TMR_W'(1);
        end
      end

      S_LOCKOUT: begin
        if (tmr_q == '0) begin
          lock_d  = 1'b0;
          try_d   = '0;
          rtry_d  = 1'b1;
          state_d = S_IDLE;
        end else begin
          tmr_d = tmr_q - TMR_W'(1);
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_IDLE;
      buf_q   <= '0;
      shd_q   <= '0;
      code_q  <= DEFAULT_CODE;
      cnt_q   <= '0;
      tmr_q   <= '0;
      try_q   <= '0;
      z_q     <= 1'b0;
      lock_q  <= 1'b0;
      prog_q  <= 1'b0;
      rtry_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      buf_q   <= buf_d;
      shd_q   <= shd_d;
      code_q  <= code_d;
      cnt_q   <= cnt_d;
      tmr_q   <= tmr_d;
      try_q   <= try_d;
      z_q     <= z_d;
      lock_q  <= lock_d;
      prog_q  <= prog_d;
      rtry_q  <= rtry_d;
    end
  end

  assign bus.z         = z_q;
  assign bus.try_cnt   = try_q;
  assign bus.reset_try = rtry_q;
  assign bus.lockout   = lock_q;
  assign bus.prog_mode = prog_q;
  assign bus.key_stb   = key.stb;
  assign bus.key_code  = key.code;
endmodule

// File: tb/tb_lock_entry_ctrl.sv
// Directed bench for lock_entry_ctrl: key-qualifier vector table plus multi-cycle scenarios.
module tb_lock_entry_ctrl;
  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  lock_entry_ctrl_if bus ();
  lock_entry_ctrl dut (.clk(clk), .rst(rst), .bus(bus));

  int n_chk = 0;
  int n_pass = 0;

  // negedge monitor: event counters and timestamps
  int cyc_n = 0, stb_cnt = 0, z_cnt = 0, rt_cnt = 0, lock_cnt = 0;
  int last_stb_cyc = 0, z_rise_cyc = 0;
  logic [3:0] last_code = '0;
  logic z_prev = 1'b0;

  always @(negedge clk) begin
    cyc_n <= cyc_n + 1;
    if (bus.key_stb) begin
      stb_cnt      <= stb_cnt + 1;
      last_code    <= bus.key_code;
      last_stb_cyc <= cyc_n;
    end
    if (bus.z) z_cnt <= z_cnt + 1;
    if (bus.z && !z_prev) z_rise_cyc <= cyc_n;
    z_prev <= bus.z;
    if (bus.reset_try) rt_cnt <= rt_cnt + 1;
    if (bus.lockout) lock_cnt <= lock_cnt + 1;
  end

  typedef struct {
    logic [15:0] x;
    int          hold;
    int          exp_stb;
    int          exp_code;
  } vec_t;

  vec_t tbl [11];

  task automatic check(input string name, input int act, input int exp);
    n_chk++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic press(input int k);
    logic [15:0] one;
    one = 16'd1;
    bus.x = one << k;
    cyc(2);
    bus.x = '0;
    cyc(2);
  endtask

  task automatic enter(input int a, input int b, input int c, input int d);
    press(a); press(b); press(c); press(d);
  endtask

  function automatic int outs_packed();
    return int'({bus.z, bus.lockout, bus.reset_try, bus.key_stb, bus.prog_mode, bus.try_cnt});
  endfunction

  initial begin
    int s0, z0, rt0, lk0;

    tbl[0]  = '{16'h0003,  3, 0, 0};
    tbl[1]  = '{16'h0000,  3, 0, 0};
    tbl[2]  = '{16'h0002, 20, 1, 1};
    tbl[3]  = '{16'h0000,  3, 0, 0};
    tbl[4]  = '{16'h0002,  3, 1, 1};
    tbl[5]  = '{16'h0006,  3, 0, 0};
    tbl[6]  = '{16'h0002,  3, 0, 0};
    tbl[7]  = '{16'h0000,  3, 0, 0};
    tbl[8]  = '{16'h0001,  3, 1, 0};
    tbl[9]  = '{16'h0000,  3, 0, 0};
    tbl[10] = '{16'h8000,  3, 1, 15};

    bus.x = '0;
    bus.prog_req = 1'b0;
    rst = 1'b0;
    cyc(3);
    check("reset_outputs", outs_packed(), 0);
    rst = 1'b1;
    cyc(2);

    // key qualifier vectors; the four accepted digits 1,1,0,F form a wrong code
    for (int i = 0; i < 11; i++) begin
      s0 = stb_cnt;
      bus.x = tbl[i].x;
      cyc(tbl[i].hold);
      check($sformatf("vec%0d_stb", i), stb_cnt - s0, tbl[i].exp_stb);
      if (tbl[i].exp_stb > 0)
        check($sformatf("vec%0d_code", i), int'(last_code), tbl[i].exp_code);
    end
    bus.x = '0;
    cyc(3);
    check("vec_wrong_try", int'(bus.try_cnt), 1);

    rst = 1'b0;
    cyc(1);
    check("rst_clears_try", outs_packed(), 0);
    rst = 1'b1;
    cyc(2);

    // correct code
    s0 = stb_cnt; z0 = z_cnt; rt0 = rt_cnt;
    for (int d = 1; d <= 4; d++) begin
      press(d);
      check($sformatf("ok_code%0d", d), int'(last_code), d);
    end
    cyc(12);
    check("ok_stb_cnt", stb_cnt - s0, 4);
    check("ok_z_cycles", z_cnt - z0, 8);
    check("ok_z_latency", z_rise_cyc - last_stb_cyc, 2);
    check("ok_try", int'(bus.try_cnt), 0);
    check("ok_no_reset_try", rt_cnt - rt0, 0);

    // three wrong codes -> lockout
    z0 = z_cnt;
    enter(5, 5, 5, 5);
    check("wrong1_try", int'(bus.try_cnt), 1);
    enter(5, 5, 5, 5);
    check("wrong2_try", int'(bus.try_cnt), 2);
    check("wrong2_nolock", int'(bus.lockout), 0);
    lk0 = lock_cnt; rt0 = rt_cnt;
    enter(5, 5, 5, 5);
    check("wrong3_try", int'(bus.try_cnt), 3);
    check("wrong3_lock", int'(bus.lockout), 1);
    enter(1, 2, 3, 4);
    check("lock_still", int'(bus.lockout), 1);
    check("lock_try_held", int'(bus.try_cnt), 3);
    check("lock_no_z", z_cnt - z0, 0);
    cyc(20);
    check("lock_cycles", lock_cnt - lk0, 32);
    check("lock_end", int'(bus.lockout), 0);
    check("lock_end_try", int'(bus.try_cnt), 0);
    check("lock_reset_try", rt_cnt - rt0, 1);

    // full timeout, then a clean entry
    press(1); press(2);
    cyc(70);
    check("tout_try", int'(bus.try_cnt), 0);
    z0 = z_cnt;
    enter(1, 2, 3, 4);
    cyc(10);
    check("tout_then_ok", z_cnt - z0, 8);

    // key landing on the timeout cycle wins
    press(1); press(2);
    cyc(60);
    press(3); press(4);
    check("tout_key_wins", int'(bus.z), 1);
    cyc(10);

    // key one cycle after the timeout starts a new entry
    z0 = z_cnt;
    press(1); press(2);
    cyc(61);
    press(3); press(4);
    cyc(4);
    check("tout_past_noz", z_cnt - z0, 0);
    check("tout_past_try", int'(bus.try_cnt), 0);
    cyc(70);

    // programming
    enter(1, 2, 3, 4);
    bus.prog_req = 1'b1;
    cyc(1);
    bus.prog_req = 1'b0;
    check("prog_mode_on", int'(bus.prog_mode), 1);
    check("prog_z_drop", int'(bus.z), 0);
    enter(9, 8, 7, 6);
    check("prog_mode_off", int'(bus.prog_mode), 0);
    z0 = z_cnt;
    enter(1, 2, 3, 4);
    check("prog_old_try", int'(bus.try_cnt), 1);
    check("prog_old_noz", z_cnt - z0, 0);
    rt0 = rt_cnt;
    enter(9, 8, 7, 6);
    cyc(10);
    check("prog_new_z", z_cnt - z0, 8);
    check("prog_new_try", int'(bus.try_cnt), 0);
    check("prog_new_rt", rt_cnt - rt0, 1);

    // prog_req on the last unlock cycle, then abort by timeout
    z0 = z_cnt;
    enter(9, 8, 7, 6);
    cyc(7);
    bus.prog_req = 1'b1;
    cyc(1);
    bus.prog_req = 1'b0;
    check("prog_last_cyc", int'(bus.prog_mode), 1);
    check("prog_last_zcnt", z_cnt - z0, 8);
    cyc(70);
    check("prog_abort", int'(bus.prog_mode), 0);
    enter(9, 8, 7, 6);
    check("prog_abort_keep", int'(bus.z), 1);
    cyc(10);

    // reset during lockout restores default code
    enter(5, 5, 5, 5);
    enter(5, 5, 5, 5);
    enter(5, 5, 5, 5);
    cyc(3);
    check("rlock_pre", int'(bus.lockout), 1);
    rst = 1'b0;
    cyc(1);
    check("rlock_outputs", outs_packed(), 0);
    rst = 1'b1;
    cyc(2);
    enter(1, 2, 3, 4);
    check("rlock_default_code", int'(bus.z), 1);
    cyc(10);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/lock_entry_ctrl.md
Name: lock_entry_ctrl

Overview:
Keypad sequencing controller for the door-lock datapath.
- Qualifies the 16-line one-hot keypad bus `x` and encodes each accepted press to a 4-bit digit.
- Assembles CODE_LEN digits and compares them against a stored code.
- Drives the unlock output `z`, the failed-attempt counter `try_cnt` and the `reset_try` pulse.
- Enforces a lockout window after MAX_TRY failures.
- Allows the code to be reprogrammed while unlocked.

Parameters:
- CODE_LEN, 4: digits per code.
- DEFAULT_CODE, 16'h1234: code loaded at reset; 4*CODE_LEN bits; first digit in the MS nibble.
- MAX_TRY, 3: failures that trigger lockout.
- UNLOCK_CYC, 8: cycles `z` stays high.
- LOCK_CYC, 32: lockout duration in cycles.
- TIMEOUT_CYC, 64: idle cycles that abort a partial entry.

Ports:
- clk, input, 1: system clock, rising edge.
- rst, input, 1: asynchronous, active-low reset.
- x, input, 16: keypad lines; bit k=1 means key k is pressed; all zeros means no key.
- prog_req, input, 1: request code programming; honoured only in UNLOCK.
- z, output, 1: unlock.
- try_cnt, output, $clog2(MAX_TRY+1): consecutive failed attempts.
- reset_try, output, 1: one-cycle pulse when try_cnt is cleared.
- lockout, output, 1: high during the lockout window.
- key_stb, output, 1: one-cycle pulse per accepted key.
- key_code, output, 4: encoded key; valid while key_stb is high.
- prog_mode, output, 1: high in PROG.

Behaviour:
- Reset (rst=0, asynchronous):
  - state=IDLE.
  - All outputs 0, try_cnt=0, digit buffer cleared.
  - Stored code=DEFAULT_CODE.
  - Reset mid-operation behaves identically in every state.
- Key qualifier:
  - x is registered to x_q.
  - A key is accepted when x_q is exactly one-hot and the previous x_q was all-zero, so release is required between presses.
  - Multi-hot x_q is ignored and does not count as a release.
  - Latency: x stable before edge E → key_stb high for exactly the cycle after edge E+1.
  - key_code = index of the set bit.
  - key_stb asserts in every state; only ENTRY/IDLE/PROG consume it.
- States: IDLE, ENTRY, CHECK, UNLOCK, PROG, LOCKOUT.
  - IDLE: key_stb → shift digit into buffer, digit count=1, go to ENTRY.
  - ENTRY:
    - key_stb shifts the digit in; the first digit ends in the MS nibble.
    - When count reaches CODE_LEN, go to CHECK.
    - An idle counter reloads on each key; at TIMEOUT_CYC idle cycles, clear the buffer and go to IDLE. try_cnt is unchanged.
  - CHECK (1 cycle): compare the buffer with the stored code.
    - Match: try_cnt=0; reset_try pulses if try_cnt was nonzero; go to UNLOCK.
    - Mismatch: try_cnt+1. If the new value equals MAX_TRY go to LOCKOUT, else go to IDLE.
  - UNLOCK:
    - z=1 for exactly UNLOCK_CYC cycles, starting the cycle after CHECK.
    - Keys are ignored.
    - prog_req=1 in any UNLOCK cycle → go to PROG; z drops the next cycle.
    - Otherwise return to IDLE when the counter expires.
  - PROG:
    - prog_mode=1.
    - Collect CODE_LEN digits into a shadow buffer.
    - On the last digit, commit it to the stored code and go to IDLE.
    - Timeout (TIMEOUT_CYC) aborts: stored code unchanged, go to IDLE.
  - LOCKOUT:
    - lockout=1 for LOCK_CYC cycles.
    - try_cnt holds MAX_TRY; all keys and prog_req are ignored.
    - On expiry: try_cnt=0, reset_try pulses for 1 cycle, go to IDLE.
- Counters:
  - try_cnt saturates at MAX_TRY and never wraps.
  - Timers are sized $clog2(max(LOCK_CYC, TIMEOUT_CYC, UNLOCK_CYC)+1).
- Simultaneous events:
  - A key arriving on the same cycle as a timeout is accepted; the key wins and reloads the timer.
  - prog_req on the last UNLOCK cycle enters PROG.

Decomposition:
- Package lock_pkg holds:
  - the state enum;
  - DIGIT_W=4 and KEY_LINES=16;
  - a onehot-to-index encode function.
- Sub-module key_qualifier: x register, one-hot/release detection, key_stb and key_code generation.
- The FSM, digit buffers and timers stay in lock_entry_ctrl.

Test Plan:
- Correct code:
  - Stimulus: x=0002, 0000, 0004, 0000, 0008, 0000, 0010, each 2 cycles.
  - Response: four key_stb pulses with codes 1, 2, 3, 4; z=1 for 8 cycles; try_cnt=0; no reset_try.
- Three wrong codes (5,5,5,5):
  - Response: try_cnt steps 1, 2, 3; lockout=1 for 32 cycles.
  - A correct code entered during lockout gives z=0.
  - At expiry: try_cnt=0 and reset_try is a single pulse.
- Invalid and held input:
  - x=0003: no key_stb.
  - x=0002 held 20 cycles: exactly one key_stb.
  - x=0002 → 0006 → 0002 without going through 0000: still one key_stb total.
- Timeout:
  - Digits 1, 2, then 64 idle cycles → state IDLE, try_cnt unchanged.
  - Then 1, 2, 3, 4 → z=1.
- Programming:
  - Unlock, assert prog_req, enter 9, 8, 7, 6 → prog_mode falls and the code becomes 0x9876.
  - Then 1,2,3,4 → try_cnt=1; 9,8,7,6 → z=1.
- Reset in lockout and after reprogramming:
  - rst=0 during lockout → all outputs 0.
  - Stored code returns to 0x1234 after reprogramming.
